// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among three byte-stream requesters
// (0 = banner/prompt FSM, 1 = cipher output, 2 = status/diagnostic).
// Requesters are served round-robin. A requester keeps the transmitter
// (packet lock) until it presents a byte flagged req_last, so a multi-byte
// message is never interleaved with bytes from another requester.
//
// Only one byte is ever in flight. After each start strobe the arbiter waits
// for the UART busy flag to rise (bounded by BUSY_WAIT cycles) and then fall.
//
// Ports:
//   clk        in   system clock (12 MHz)
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]    per-requester byte valid
//   req_data   in   [8*NREQ]  per-requester byte, [8i+7:8i] = requester i
//   req_last   in   [NREQ]    byte closes a packet and releases the lock
//   req_ready  out  [NREQ]    one-cycle accept pulse for the granted requester
//   tx_start   out  one-cycle start strobe to the UART TX block
//   tx_data    out  [8] byte to the UART, stable from tx_start until busy falls
//   tx_busy    in   UART TX busy flag
//   grant_id   out  [2] current or most recently granted requester
//   locked     out  a packet lock is held
//
// Optional feature (macro UART_ARB_STATS_EN):
//   byte_cnt   out  [16*NREQ] saturating count of accepted bytes per requester
//   drop_cnt   out  [8]       saturating count of locks dropped by hold timeout
// With the macro undefined these ports and counters do not exist.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NREQ         = 3,
   parameter int BUSY_WAIT    = 4,
   parameter int HOLD_TIMEOUT = 12000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic [1:0]        grant_id,
   output logic              locked
`ifdef UART_ARB_STATS_EN
   ,
   output logic [16*NREQ-1:0] byte_cnt,
   output logic [7:0]         drop_cnt
`endif
);

   localparam int BW_W   = $clog2(BUSY_WAIT + 1);
   localparam int IDLE_W = $clog2(HOLD_TIMEOUT + 1);

   localparam logic [BW_W-1:0]   BUSY_LAST = BW_W'(BUSY_WAIT - 1);
   localparam logic [IDLE_W-1:0] HOLD_LAST = IDLE_W'(HOLD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   // Requester index successor, modulo 3.
   function automatic logic [1:0] next_idx(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   state_t              state_q,    state_d;
   logic [1:0]          grant_q,    grant_d;
   logic                locked_q,   locked_d;
   logic [1:0]          rr_ptr_q,   rr_ptr_d;
   logic                last_q,     last_d;
   logic [7:0]          tx_data_q,  tx_data_d;
   logic [BW_W-1:0]     busy_cnt_q, busy_cnt_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

   logic [1:0]          cand1;
   logic [1:0]          cand2;
   logic [1:0]          pick;
   logic                any_valid;
   logic                hold_drop;

   // Round-robin search starting at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2.
   always_comb begin
      cand1     = next_idx(rr_ptr_q);
      cand2     = next_idx(cand1);
      any_valid = |req_valid;
      pick      = rr_ptr_q;
      if (req_valid[rr_ptr_q]) begin
         pick = rr_ptr_q;
      end else if (req_valid[cand1]) begin
         pick = cand1;
      end else if (req_valid[cand2]) begin
         pick = cand2;
      end
   end

   // Locked owner has been silent for HOLD_TIMEOUT idle cycles: this cycle
   // is the last one the lock is held.
   assign hold_drop = (state_q == S_IDLE) && locked_q && !req_valid[grant_q] &&
                      (idle_cnt_q == HOLD_LAST);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      locked_d   = locked_q;
      rr_ptr_d   = rr_ptr_q;
      last_d     = last_q;
      tx_data_d  = tx_data_q;
      busy_cnt_d = busy_cnt_q;
      idle_cnt_d = idle_cnt_q;

      case (state_q)
         S_IDLE: begin
            // The byte is latched on the way into ISSUE so that tx_data is
            // already valid during the tx_start cycle.
            if (locked_q) begin
               if (req_valid[grant_q]) begin
                  if (!tx_busy) begin
                     state_d    = S_ISSUE;
                     idle_cnt_d = '0;
                     tx_data_d  = req_data[{grant_q, 3'b000} +: 8];
                  end
               end else if (hold_drop) begin
                  locked_d   = 1'b0;
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end else if (any_valid && !tx_busy) begin
               grant_d    = pick;
               locked_d   = 1'b1;
               state_d    = S_ISSUE;
               idle_cnt_d = '0;
               tx_data_d  = req_data[{pick, 3'b000} +: 8];
            end
         end

         S_ISSUE: begin
            last_d     = req_last[grant_q];
            busy_cnt_d = '0;
            state_d    = S_WAIT_BUSY;
         end

         S_WAIT_BUSY: begin
            // Give up waiting for busy after BUSY_WAIT cycles so a UART that
            // never raises busy cannot stall the arbiter.
            if (tx_busy || (busy_cnt_q == BUSY_LAST)) begin
               state_d = S_WAIT_DONE;
            end else begin
               busy_cnt_d = busy_cnt_q + 1'b1;
            end
         end

         S_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = S_IDLE;
               if (last_q) begin
                  // Packet finished: previous grantee drops to lowest priority.
                  locked_d = 1'b0;
                  rr_ptr_d = next_idx(grant_q);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= 2'd0;
         locked_q   <= 1'b0;
         rr_ptr_q   <= 2'd0;
         last_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         locked_q   <= locked_d;
         rr_ptr_q   <= rr_ptr_d;
         last_q     <= last_d;
         tx_data_q  <= tx_data_d;
         busy_cnt_q <= busy_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // Strobes decode straight from registered state, so they are glitch-free
   // and drop to zero the instant reset is asserted.
   always_comb begin
      req_ready = '0;
      if (state_q == S_ISSUE) begin
         req_ready[grant_q] = 1'b1;
      end
   end

   assign tx_start = (state_q == S_ISSUE);
   assign tx_data  = tx_data_q;
   assign grant_id = grant_q;
   assign locked   = locked_q;

`ifdef UART_ARB_STATS_EN
   logic [16*NREQ-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i] && (byte_cnt_q[16*i +: 16] != 16'hFFFF)) begin
            byte_cnt_d[16*i +: 16] = byte_cnt_q[16*i +: 16] + 16'd1;
         end
      end
      drop_cnt_d = drop_cnt_q;
      if (hold_drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         drop_cnt_q <= 8'h00;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign byte_cnt = byte_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [2:0]  req_valid = 3'b000;
   logic [23:0] req_data  = 24'h0;
   logic [2:0]  req_last  = 3'b000;
   logic [2:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy   = 1'b0;
   logic [1:0]  grant_id;
   logic        locked;
`ifdef UART_ARB_STATS_EN
   logic [47:0] byte_cnt;
   logic [7:0]  drop_cnt;
`endif

   uart_tx_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .locked    (locked)
`ifdef UART_ARB_STATS_EN
      ,
      .byte_cnt  (byte_cnt),
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int viol      = 0;
   int cyc       = 0;
   int busy_len  = 3;   // cycles the UART model holds busy; 0 = never busy
   int busy_left = 0;
   bit pend      = 1'b0;
   int t0;

   // Per-requester byte queues: {last, data}
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];

   // One entry per tx_start cycle
   logic [7:0] log_data[$];
   logic [2:0] log_rdy[$];
   int         log_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      req_valid = 3'b000;
      req_data  = 24'h0;
      req_last  = 3'b000;
      if (q0.size() > 0) begin
         req_valid[0] = 1'b1; req_data[7:0]   = q0[0][7:0]; req_last[0] = q0[0][8];
      end
      if (q1.size() > 0) begin
         req_valid[1] = 1'b1; req_data[15:8]  = q1[0][7:0]; req_last[1] = q1[0][8];
      end
      if (q2.size() > 0) begin
         req_valid[2] = 1'b1; req_data[23:16] = q2[0][7:0]; req_last[2] = q2[0][8];
      end
   endtask

   // One clock: mid-cycle sample + UART model, then requester update after the edge.
   task automatic tick();
      logic [2:0] rdy;
      @(negedge clk);
      rdy = req_ready;
      if (tx_start) begin
         log_data.push_back(tx_data);
         log_rdy.push_back(req_ready);
         log_cyc.push_back(cyc);
      end
      // UART model: busy rises one cycle after the start strobe.
      if (busy_left > 0) busy_left--;
      if (pend) begin
         busy_left = busy_len;
         pend      = 1'b0;
      end
      if (tx_start && busy_len > 0) pend = 1'b1;
      tx_busy = (busy_left > 0);
      if (tx_start && tx_busy) viol++;
      if (rdy != 3'b000 && !tx_start) viol++;
      if (rdy != 3'b000 && rdy != (3'b001 << grant_id)) viol++;
      @(posedge clk);
      cyc++;
      #1;
      if (rdy[0]) void'(q0.pop_front());
      if (rdy[1]) void'(q1.pop_front());
      if (rdy[2]) void'(q2.pop_front());
      drive_reqs();
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int k = 0;
      while (log_data.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, log_data.size(), n);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int k = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && !locked && !tx_busy)
             && k < budget) begin
         tick();
         k++;
      end
      chk(tag, {q0.size() != 0, q1.size() != 0, q2.size() != 0, locked, tx_busy}, 0);
   endtask

   task automatic expect_log(input int idx, input logic [7:0] d, input logic [2:0] r,
                             input string tag);
      chk({tag, "_data"}, log_data[idx], d);
      chk({tag, "_ready"}, log_rdy[idx], r);
   endtask

   task automatic clear_log();
      log_data.delete();
      log_rdy.delete();
      log_cyc.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_tx_start", tx_start, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_locked", locked, 0);
      rst_n = 1'b1;
      tick();

      // Single byte from requester 1; arbitration costs one cycle.
      clear_log();
      q1.push_back({1'b1, 8'h41});
      drive_reqs();
      t0 = cyc;
      wait_starts(1, 20, "t1_start");
      expect_log(0, 8'h41, 3'b010, "t1");
      chk("t1_latency", log_cyc[0] - t0, 1);
      wait_drain(50, "t1_drain");
      chk("t1_grant", grant_id, 1);

      // rr_ptr=2 now: requester 2 beats requester 0.
      clear_log();
      q0.push_back({1'b1, 8'h10});
      q2.push_back({1'b1, 8'h30});
      drive_reqs();
      wait_starts(2, 40, "t2_start");
      expect_log(0, 8'h30, 3'b100, "t2_0");
      expect_log(1, 8'h10, 3'b001, "t2_1");
      wait_drain(50, "t2_drain");

      // rr_ptr=1: requester 1 before 2.
      clear_log();
      q1.push_back({1'b1, 8'h21});
      q2.push_back({1'b1, 8'h32});
      drive_reqs();
      wait_starts(2, 40, "t2b_start");
      expect_log(0, 8'h21, 3'b010, "t2b_0");
      expect_log(1, 8'h32, 3'b100, "t2b_1");
      wait_drain(50, "t2b_drain");

      // Packet lock, rr_ptr=0: "HI\r" from requester 0, requester 2 waiting.
      clear_log();
      q0.push_back({1'b0, 8'h48});
      q0.push_back({1'b0, 8'h49});
      q0.push_back({1'b1, 8'h0D});
      q2.push_back({1'b1, 8'h77});
      drive_reqs();
      wait_starts(4, 80, "t3_start");
      expect_log(0, 8'h48, 3'b001, "t3_0");
      expect_log(1, 8'h49, 3'b001, "t3_1");
      expect_log(2, 8'h0D, 3'b001, "t3_2");
      expect_log(3, 8'h77, 3'b100, "t3_3");
      wait_drain(50, "t3_drain");

      // Round-robin, rr_ptr=0, all continuously valid with single-byte packets.
      clear_log();
      q0.push_back({1'b1, 8'hA0}); q0.push_back({1'b1, 8'hA1});
      q1.push_back({1'b1, 8'hB0}); q1.push_back({1'b1, 8'hB1});
      q2.push_back({1'b1, 8'hC0}); q2.push_back({1'b1, 8'hC1});
      drive_reqs();
      wait_starts(6, 120, "t4_start");
      expect_log(0, 8'hA0, 3'b001, "t4_0");
      expect_log(1, 8'hB0, 3'b010, "t4_1");
      expect_log(2, 8'hC0, 3'b100, "t4_2");
      expect_log(3, 8'hA1, 3'b001, "t4_3");
      expect_log(4, 8'hB1, 3'b010, "t4_4");
      expect_log(5, 8'hC1, 3'b100, "t4_5");
      wait_drain(50, "t4_drain");

      // Busy never rises: ISSUE(1) + WAIT_BUSY(4) + WAIT_DONE(1) + IDLE(1) = 7
      // cycles per byte for a single requester re-granted each packet.
      clear_log();
      busy_len = 0;
      q1.push_back({1'b1, 8'hE0});
      q1.push_back({1'b1, 8'hE1});
      q1.push_back({1'b1, 8'hE2});
      drive_reqs();
      wait_starts(3, 60, "t5_start");
      expect_log(0, 8'hE0, 3'b010, "t5_0");
      expect_log(2, 8'hE2, 3'b010, "t5_2");
      chk("t5_gap01", log_cyc[1] - log_cyc[0], 7);
      chk("t5_gap12", log_cyc[2] - log_cyc[1], 7);
      wait_drain(50, "t5_drain");

      // Hold timeout (busy still never rises). After 0x51 at cycle c:
      // WAIT_BUSY c+1..c+4, WAIT_DONE c+5, locked IDLE c+6..c+12005
      // (12000 cycles), unlocked IDLE c+12006, ISSUE for requester 1 at c+12007.
      clear_log();
      q0.push_back({1'b0, 8'h50});
      q0.push_back({1'b0, 8'h51});
      q1.push_back({1'b1, 8'h60});
      drive_reqs();
      wait_starts(2, 40, "t6_first");
      repeat (100) tick();
      chk("t6_locked_mid", locked, 1);
      chk("t6_no_early", log_data.size(), 2);
      wait_starts(3, 13000, "t6_start");
      expect_log(0, 8'h50, 3'b001, "t6_0");
      expect_log(1, 8'h51, 3'b001, "t6_1");
      expect_log(2, 8'h60, 3'b010, "t6_2");
      chk("t6_delay", log_cyc[2] - log_cyc[1], 12007);
      wait_drain(50, "t6_drain");
      chk("t6_grant", grant_id, 1);
`ifdef UART_ARB_STATS_EN
      chk("t6_drop_cnt", drop_cnt, 1);
      chk("t6_byte_cnt", byte_cnt[47:32], 5);
      chk("t6_byte_cnt1", byte_cnt[31:16], 8);
      chk("t6_byte_cnt0", byte_cnt[15:0], 8);
`endif

      // Reset in WAIT_DONE: outputs clear before the next clock edge.
      clear_log();
      busy_len = 3;
      q2.push_back({1'b1, 8'h5A});
      drive_reqs();
      wait_starts(1, 20, "t7_start");
      for (int k = 0; k < 10 && !tx_busy; k++) tick();
      chk("t7_busy", tx_busy, 1);
      chk("t7_pre_locked", locked, 1);
      chk("t7_pre_grant", grant_id, 2);
      chk("t7_pre_data", tx_data, 8'h5A);
      rst_n = 1'b0;
      #1;
      chk("t7_tx_start", tx_start, 0);
      chk("t7_req_ready", req_ready, 0);
      chk("t7_tx_data", tx_data, 0);
      chk("t7_grant", grant_id, 0);
      chk("t7_locked", locked, 0);
      busy_left = 0;
      pend      = 1'b0;
      tx_busy   = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("t7_quiet", log_data.size(), 1);

      chk("protocol_violations", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among three byte-stream requesters: 0 = banner/prompt FSM, 1 = cipher output path, 2 = status/diagnostic. Round-robin arbitration with packet lock, so a multi-byte message is never interleaved with another requester's bytes. Sits between the requesters and the UART TX block. Drives that block's start strobe and data, and monitors its busy flag.

Parameters:
- NREQ, 3, number of requesters; fixed at 3 for this revision.
- BUSY_WAIT, 4, max cycles to wait for tx_busy to rise after tx_start before proceeding.
- HOLD_TIMEOUT, 12000, idle cycles (1 ms at 12 MHz) a locked requester may leave req_valid low before its lock is dropped.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  3  per-requester byte valid; bit i = requester i.
- req_data  in  24  per-requester byte; [8i+7:8i] = requester i.
- req_last  in  3  byte is the final byte of a packet; releases the lock.
- req_ready  out  3  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  one-cycle start strobe to the UART TX block.
- tx_data  out  8  byte to the UART TX block; held stable from tx_start until tx_busy falls.
- tx_busy  in  1  UART TX block busy flag.
- grant_id  out  2  current or last granted requester.
- locked  out  1  a packet lock is held.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, locked=0, rr_ptr=0, state=IDLE.
  - Reset mid-operation aborts immediately. The UART block recovers on its own reset.
- States:
  - IDLE
    - If locked and req_valid[grant_id]=1 → ISSUE.
    - If locked and req_valid[grant_id]=0 → count idle cycles. At HOLD_TIMEOUT, clear locked; stay IDLE.
    - If not locked and any req_valid → select the first valid requester searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Set grant_id and locked=1; → ISSUE in the same cycle.
    - Arbitration plus ISSUE entry costs one cycle.
  - ISSUE (1 cycle)
    - tx_data ← req_data[grant_id].
    - tx_start=1 and req_ready[grant_id]=1, both on the same cycle.
    - Capture req_last[grant_id] into last_q; → WAIT_BUSY.
  - WAIT_BUSY
    - → WAIT_DONE when tx_busy=1, or after BUSY_WAIT cycles (tolerates a fast or absent busy assertion).
  - WAIT_DONE
    - Wait for tx_busy=0, then → IDLE.
    - If last_q=1: clear locked and set rr_ptr ← grant_id+1 (mod 3; 2 wraps to 0).
- Issue rate: at most one byte in flight. tx_start is never asserted while tx_busy=1 or outside ISSUE.
- Requester handshake:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - req_ready is never asserted for a non-granted requester. At most one bit is set per cycle.
- Simultaneous events:
  - Several requesters valid → round-robin order from rr_ptr.
  - A requester that drops req_valid during ISSUE has still had its byte consumed, since the capture is registered.
- Fairness: after a packet end, the previous grantee has the lowest priority. A single continuously valid requester is re-granted with no extra penalty.
- Idle counter: resets on any ISSUE entry. Width is clog2(HOLD_TIMEOUT+1).

Optional Feature:
UART_ARB_STATS_EN
- Defined: adds outputs byte_cnt (3×16 bits, packed) and drop_cnt (8 bits).
  - byte_cnt[i] increments on each req_ready[i] pulse and saturates at 16'hFFFF.
  - drop_cnt increments, saturating at 8'hFF, on each HOLD_TIMEOUT lock release.
  - Both reset to 0.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
- Single byte: requester 1 presents 0x41 with last=1 → tx_start and req_ready[1] on the same cycle, tx_data=0x41; after tx_busy falls, locked=0 and rr_ptr=2.
- Packet lock: requester 0 sends "HI\r" (last on 0x0D) while requester 2 is valid throughout → UART sees 0x48, 0x49, 0x0D, then requester 2's byte; no interleave.
- Round-robin: all three requesters continuously valid with single-byte packets and rr_ptr=0 → grant order 0,1,2,0,1,2; each req_ready pulses once per 3 bytes.
- Busy timeout: tx_busy tied low → FSM leaves WAIT_BUSY after BUSY_WAIT=4 cycles and bytes continue to issue; tx_start is never back-to-back with fewer than 6 cycles between pulses.
- Hold timeout: requester 0 sends 2 bytes with last=0 then drops valid; requester 1 is valid → requester 1 is granted exactly 12000 idle cycles later (drop_cnt=1 with UART_ARB_STATS_EN).
- Reset mid-byte: assert rst_n=0 in WAIT_DONE → all outputs are at reset values asynchronously, before the next clk edge.
